// File: rtl/fir_mac_sequencer.sv
// Sequencer for a direct-form FIR: one multiply-accumulate per cycle against an
// external coefficient/sample memory, with results handed off over valid/ready.
module fir_mac_sequencer #(
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_ADDR_WIDTH = 6,
  parameter int DATA_WIDTH      = 32,
  parameter int ACC_WIDTH       = 68,
  parameter int MEM_LATENCY     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [ADDR_WIDTH-1:0]      h_addr,
  output logic [DATA_ADDR_WIDTH-1:0] x_addr,
  output logic                       R_en,
  input  logic [DATA_WIDTH-1:0]      h_in,
  input  logic [DATA_WIDTH-1:0]      x_in,
  output logic [ACC_WIDTH-1:0]       y,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic                       busy,
  output logic                       done
);
  // Handshake: a result transfers on every rising edge where y_valid && y_ready;
  // once raised, y_valid and y stay stable until that transfer happens.
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t                     state;
  logic [ADDR_WIDTH-1:0]      k;
  logic [DATA_ADDR_WIDTH-1:0] n;
  logic [2:0]                 dcnt;

  logic tag_v [0:MEM_LATENCY];
  logic tag_f [0:MEM_LATENCY];
  logic tag_z [0:MEM_LATENCY];

  logic                        prod_v;
  logic                        prod_f;
  logic signed [PW-1:0]        prod;
  logic signed [PW-1:0]        h_ext;
  logic signed [PW-1:0]        x_ext;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;

  logic                       issue_go;
  logic [ADDR_WIDTH-1:0]      issue_k;
  logic [DATA_ADDR_WIDTH-1:0] issue_n;
  logic                       issue_zero;

  // Next tap to put on the memory bus, decided from the current state.
  always_comb begin
    issue_go = 1'b0;
    issue_k  = '0;
    issue_n  = n;
    case (state)
      IDLE: begin
        issue_go = start;
        issue_n  = '0;
      end
      ISSUE: begin
        issue_go = ~&k;
        issue_k  = k + ADDR_WIDTH'(1);
      end
      OUT: begin
        issue_go = y_ready & ~&n;
        issue_n  = n + DATA_ADDR_WIDTH'(1);
      end
      default: ;
    endcase
  end

  // Taps reaching back before x[0] would read wrapped samples; they are zeroed.
  assign issue_zero = 32'(issue_k) > 32'(issue_n);

  assign h_ext    = {{DATA_WIDTH{h_in[DATA_WIDTH-1]}}, h_in};
  assign x_ext    = {{DATA_WIDTH{x_in[DATA_WIDTH-1]}}, x_in};
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

  always_comb begin
    acc_next = acc;
    if (prod_v) acc_next = prod_f ? prod_ext : acc + prod_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      n       <= '0;
      dcnt    <= '0;
      h_addr  <= '0;
      x_addr  <= '0;
      R_en    <= 1'b0;
      y       <= '0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      prod_v  <= 1'b0;
      prod_f  <= 1'b0;
      prod    <= '0;
      acc     <= '0;
      for (int i = 0; i <= MEM_LATENCY; i++) begin
        tag_v[i] <= 1'b0;
        tag_f[i] <= 1'b0;
        tag_z[i] <= 1'b0;
      end
    end else begin
      done <= 1'b0;
      R_en <= issue_go;
      if (issue_go) begin
        h_addr <= issue_k;
        x_addr <= issue_n - DATA_ADDR_WIDTH'(issue_k);
        k      <= issue_k;
        n      <= issue_n;
      end

      // Tags travel alongside the memory read so they meet h_in/x_in.
      tag_v[0] <= issue_go;
      tag_f[0] <= (issue_k == '0);
      tag_z[0] <= issue_zero;
      for (int i = 1; i <= MEM_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_f[i] <= tag_f[i-1];
        tag_z[i] <= tag_z[i-1];
      end

      prod_v <= tag_v[MEM_LATENCY];
      prod_f <= tag_f[MEM_LATENCY];
      prod   <= tag_z[MEM_LATENCY] ? '0 : h_ext * x_ext;
      acc    <= acc_next;

      case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (&k) begin
            state <= DRAIN;
            dcnt  <= '0;
          end
        end
        DRAIN: begin
          // Last product folds in during the final drain cycle.
          if (dcnt == 3'(MEM_LATENCY)) begin
            state   <= OUT;
            y_valid <= 1'b1;
            y       <= acc_next;
          end else begin
            dcnt <= dcnt + 3'd1;
          end
        end
        OUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            if (&n) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Sits directly downstream of the coefficient/sample memory block. Drives its h_addr, x_addr and R_en, and consumes its h_out and x_out.
- Computes a direct-form FIR: y[n] = sum over k=0..TAPS-1 of h[k]*x[n-k], with x[negative] = 0, for n = 0..NUM_OUT-1.
- Uses one multiply-accumulate per cycle. Results leave through a valid/ready handshake to the output stage.

Parameters:
- ADDR_WIDTH, 4, coefficient address width; TAPS = 2**ADDR_WIDTH (16).
- DATA_ADDR_WIDTH, 6, sample address width; NUM_OUT = 2**DATA_ADDR_WIDTH (64).
- DATA_WIDTH, 32, signed two's-complement width of h and x.
- ACC_WIDTH, 68, signed accumulator and y width; must be >= 2*DATA_WIDTH+ADDR_WIDTH.
- MEM_LATENCY, 1, cycles from address/R_en to valid memory data; legal values 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  active-low asynchronous reset.
- start  in  1  one-cycle pulse that begins a full NUM_OUT-output run.
- h_addr  out  ADDR_WIDTH  coefficient address to memory.
- x_addr  out  DATA_ADDR_WIDTH  sample address to memory.
- R_en  out  1  memory read enable.
- h_in  in  DATA_WIDTH  coefficient data from memory (h_out).
- x_in  in  DATA_WIDTH  sample data from memory (x_out).
- y  out  ACC_WIDTH  filter output, signed full precision.
- y_valid  out  1  y holds a result.
- y_ready  in  1  downstream accepts y.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when the run completes.

Behaviour:
- Clocking/reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: h_addr=0, x_addr=0, R_en=0, y=0, y_valid=0, busy=0, done=0. Accumulator, pipeline tags, n=0 and k=0 are also cleared.
- Reset mid-run aborts the run. No partial result is output.
- States:
  - IDLE: start=1 -> ISSUE with n=0, k=0, busy=1. start is ignored in every other state.
  - ISSUE: one cycle per tap. Drive R_en=1, h_addr=k, x_addr=(n-k) mod NUM_OUT. Tag the slot with first=(k==0) and zero=(k>n). After k=TAPS-1 -> DRAIN.
  - DRAIN: R_en=0, addresses hold their last value. Wait MEM_LATENCY+1 cycles -> OUT.
  - OUT: y_valid=1, y=accumulator. y and y_valid are held stable until y_valid&&y_ready. On that handshake:
    - if n<NUM_OUT-1: n++, k=0, -> ISSUE in the next cycle.
    - else: -> IDLE, done=1 for one cycle, busy=0 in that same cycle.
- Pipeline per tap:
  - Tags delay by MEM_LATENCY to align with h_in/x_in.
  - Product register: h_in*x_in as a signed 2*DATA_WIDTH value, forced to 0 when zero=1.
  - Accumulate on the next edge: acc = first ? sign-extended product : acc + sign-extended product.
- Latency: y_valid rises TAPS+MEM_LATENCY+1 cycles after the first ISSUE cycle of that output (18 with defaults).
- No overlap between outputs. Minimum period per output is TAPS+MEM_LATENCY+2 cycles.
- Arithmetic: all signed. Product and accumulator are sign-extended to ACC_WIDTH. There is no saturation or truncation; default widths cannot overflow.
- Boundary, n<TAPS-1: x_addr wraps modulo NUM_OUT, but those products are zeroed, so wrapped samples never contribute.
- Backpressure: while y_valid=1 and y_ready=0, no addresses are issued and R_en=0.
- y_ready while y_valid=0 has no effect.

Test Plan:
- h[0]=1, h[1..15]=0, x[i]=i; start -> y[n]=n for n=0..63, 64 handshakes, done pulses once after the 64th handshake.
- h all 1, x all 1 -> y[0]=1, y[1]=2, y[14]=15, y[15..63]=16. Confirms zero-gating of wrapped addresses.
- h[0]=-1 (0xFFFFFFFF), x all 0x80000000, other h=0 -> every y = +2^31 (0x0_8000_0000 in 68 bits). Confirms signed sign-extension.
- y_ready held high, MEM_LATENCY=1:
  - first y_valid 18 cycles after the first R_en=1 cycle.
  - R_en high exactly 16 consecutive cycles per output, with h_addr 0..15 and x_addr=(n-k) mod 64.
- Backpressure: y_ready=0 for 5 cycles at output n=3 -> y stable, R_en=0 throughout, n=4 issue begins the cycle after the handshake. A start pulse mid-run is ignored.
- Reset: rst_n=0 during ISSUE of n=10 -> all outputs return to their reset values immediately (asynchronous). After release, a new start produces y[0] correctly.
